div_job_sequencer: RTL
======================

// Module: div_job_sequencer
// PURPOSE
//  Front/back-end sequencer for the 12/6 restoring divider core. Accepts dividend/divisor jobs
//  via valid/ready, screens divide-by-zero and quotient overflow, launches the core with a
//  one-cycle start pulse, and waits for done with a timeout. Holds Q/Rem/status in an output
//  register until the consumer accepts it. Only one job is in flight at a time; there is no bypass.
// PARAMETERS
//  DW        6   divisor width; dividend is 2*DW, quotient DW, remainder DW+1
//  TIMEOUT   31  max WAIT cycles without div_done before timeout error (>=2)
// PORTS
//  clk        in   1       system clock, rising edge
//  rst        in   1       async active-high reset
//  in_valid   in   1       job offered
//  in_ready   out  1       sequencer can accept job (IDLE only)
//  in_AQ      in   2*DW    dividend
//  in_D       in   DW      divisor
//  div_start  out  1       one-cycle launch pulse to divider core
//  div_AQ     out  2*DW    dividend to core, held stable from capture until next capture
//  div_D      out  DW      divisor to core, held stable likewise
//  div_done   in   1       core completion pulse; sampled only in WAIT
//  div_Q      in   DW      core quotient, valid with div_done
//  div_Rem    in   DW+1    core remainder, valid with div_done
//  out_valid  out  1       result held
//  out_ready  in   1       consumer accepts result
//  out_Q      out  DW      quotient
//  out_Rem    out  DW+1    remainder
//  out_err    out  2       00 ok, 01 div-by-zero, 10 overflow, 11 timeout
//  busy       out  1       state != IDLE
// BEHAVIOUR
//  States: IDLE -> CHECK -> ISSUE -> WAIT -> RESULT -> IDLE; CHECK -> RESULT on error.
//  Reset (async, any state): state=IDLE; div_start=0, out_valid=0, out_Q=0, out_Rem=0,
//    out_err=00, div_AQ=0, div_D=0, timeout count=0, busy=0. in_ready=1 (decoded from IDLE).
//  IDLE: in_ready=1. When in_valid&in_ready, latch in_AQ/in_D into div_AQ/div_D and go to CHECK.
//  CHECK (1 cycle):
//    div_D==0                      -> out_err=01, out_Q=0, out_Rem=0, go to RESULT
//    else div_AQ[2*DW-1:DW]>=div_D -> out_err=10, out_Q=0, out_Rem=0, go to RESULT
//      (the quotient cannot fit in DW bits)
//    else go to ISSUE. Div-by-zero takes priority over overflow.
//  ISSUE (1 cycle): div_start=1; clear the timeout count; go to WAIT. div_start is 0 in all other states.
//  WAIT: if div_done, capture div_Q/div_Rem into out_Q/out_Rem, set out_err=00, go to RESULT.
//    Else if count==TIMEOUT-1, set out_err=11, out_Q=0, out_Rem=0, go to RESULT.
//    Otherwise increment the count.
//    If div_done and the timeout hit occur on the same cycle, div_done wins.
//  RESULT: out_valid=1. out_Q/out_Rem/out_err stay stable while out_ready=0.
//    On out_ready, go to IDLE; out_valid drops the next cycle.
//  div_done outside WAIT is ignored. A late done after a timeout is ignored.
//  in_ready=0 in every non-IDLE state, including the cycle of the output handshake.
//  Latency, input handshake at cycle T:
//    error result valid at T+2; div_start at T+2; WAIT begins T+3.
//    done sampled at cycle W -> out_valid at W+1.
//  Minimum job-to-job spacing: the result handshake cycle plus 1 IDLE cycle.
//  out_Q/out_Rem/out_err keep their last values after the handshake until the next update.
// TESTING
//  1 in_AQ=100, in_D=7, core model done after 8 cycles returning Q=14, Rem=2
//    -> one div_start pulse at T+2; out_valid with Q=14, Rem=2, err=00.
//  2 in_AQ=0x055, in_D=0 -> no div_start; out_valid at T+2 with err=01, Q=0, Rem=0.
//  3 in_AQ=0x1C0, in_D=7 (high half 7 >= 7) -> no div_start; err=10 at T+2.
//    Repeat with in_AQ=0x1BF (high half 6): the job issues normally.
//  4 core never asserts done, TIMEOUT=31 -> err=11 exactly 31 WAIT cycles after entry;
//    a div_done injected 2 cycles later is ignored.
//  5 out_ready held 0 for 5 cycles after result
//    -> out_* stable, in_ready=0, in_valid ignored; job 2 accepted the cycle after the handshake.
//  6 rst asserted mid-WAIT -> immediately IDLE: out_valid=0, div_start=0, busy=0, in_ready=1.
//    A subsequent job (200/9 -> Q=22, Rem=2) completes correctly.

Source files
------------

// File: rtl/div_job_sequencer.sv
// Job sequencer around a 12/6 restoring divider core: screens div-by-zero and
// quotient overflow, launches the core, times out a silent core, and holds the result.
module div_job_sequencer #(
  parameter int DW      = 6,
  parameter int TIMEOUT = 31
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2*DW-1:0] in_AQ,
  input  logic [DW-1:0]   in_D,
  output logic            div_start,
  output logic [2*DW-1:0] div_AQ,
  output logic [DW-1:0]   div_D,
  input  logic            div_done,
  input  logic [DW-1:0]   div_Q,
  input  logic [DW:0]     div_Rem,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_Q,
  output logic [DW:0]     out_Rem,
  output logic [1:0]      out_err,
  output logic            busy
);

  localparam int            CW       = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_DIV0    = 2'b01;
  localparam logic [1:0] ERR_OVF     = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ISSUE,
    S_WAIT,
    S_RESULT
  } state_e;

  state_e          state_q;
  logic [2*DW-1:0] div_aq_q;
  logic [DW-1:0]   div_d_q;
  logic            div_start_q;
  logic            out_valid_q;
  logic [DW-1:0]   out_q_q;
  logic [DW:0]     out_rem_q;
  logic [1:0]      out_err_q;
  logic [CW-1:0]   cnt_q;

  // NOTE: every register lives in one clocked block and uses <= so all state
  // advances together on the edge; the reset branch is the only async path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      div_aq_q    <= '0;
      div_d_q     <= '0;
      div_start_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_q_q     <= '0;
      out_rem_q   <= '0;
      out_err_q   <= ERR_OK;
      cnt_q       <= '0;
    end else begin
      div_start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            div_aq_q <= in_AQ;
            div_d_q  <= in_D;
            state_q  <= S_CHECK;
          end
        end
        S_CHECK: begin
          // Div-by-zero is screened first; a high half >= divisor means Q needs > DW bits.
          if (div_d_q == '0) begin
            out_err_q   <= ERR_DIV0;
            out_q_q     <= '0;
            out_rem_q   <= '0;
            out_valid_q <= 1'b1;
            state_q     <= S_RESULT;
          end else if (div_aq_q[2*DW-1:DW] >= div_d_q) begin
            out_err_q   <= ERR_OVF;
            out_q_q     <= '0;
            out_rem_q   <= '0;
            out_valid_q <= 1'b1;
            state_q     <= S_RESULT;
          end else begin
            div_start_q <= 1'b1;
            state_q     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt_q   <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (div_done) begin
            out_q_q     <= div_Q;
            out_rem_q   <= div_Rem;
            out_err_q   <= ERR_OK;
            out_valid_q <= 1'b1;
            state_q     <= S_RESULT;
          end else if (cnt_q == CNT_LAST) begin
            out_err_q   <= ERR_TIMEOUT;
            out_q_q     <= '0;
            out_rem_q   <= '0;
            out_valid_q <= 1'b1;
            state_q     <= S_RESULT;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_RESULT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign div_start = div_start_q;
  assign div_AQ    = div_aq_q;
  assign div_D     = div_d_q;
  assign out_valid = out_valid_q;
  assign out_Q     = out_q_q;
  assign out_Rem   = out_rem_q;
  assign out_err   = out_err_q;

endmodule
